id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Pipeline register between decode (register-file read) and execute in the 5-stage RV32I core.
- Captures decoded control, immediate and the two register-file read operands.
- Detects load-use hazards and inserts a one-cycle bubble.
- Provides forwarded operands to the ALU from the EX/MEM and MEM/WB results; handles branch flush and back-pressure from memory.

Parameters:
- XLEN, 32, datapath width.
- CTRL_W, 16, width of the packed decoded-control bundle (ALU op, operand selects, mem op, branch type).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  reset, asynchronous, active-low.
- id_valid  in  1  decode holds a valid instruction.
- id_pc  in  XLEN  PC of decode instruction.
- id_rs1, id_rs2, id_rd  in  5  register indices.
- id_rd1, id_rd2  in  XLEN  register-file read data; x0 already reads 0.
- id_imm  in  XLEN  sign-extended immediate.
- id_ctrl  in  CTRL_W  decoded control.
- id_reg_write  in  1  instruction writes rd.
- id_is_load  in  1  instruction is a load.
- flush  in  1  taken branch/jump resolved in EX; kill ID and ID/EX contents.
- mem_stall  in  1  downstream busy; freeze ID/EX.
- mem_rd  in  5, mem_reg_write  in  1, mem_result  in  XLEN  EX/MEM forward source.
- wb_rd  in  5, wb_reg_write  in  1, wb_result  in  XLEN  MEM/WB forward source.
- id_stall  out  1  hold PC and IF/ID this cycle.
- ex_valid  out  1  EX stage holds a valid instruction.
- ex_pc, ex_imm  out  XLEN  registered values.
- ex_ctrl  out  CTRL_W  registered control.
- ex_rd  out  5, ex_reg_write  out  1, ex_is_load  out  1  registered.
- ex_op1, ex_op2  out  XLEN  forwarded rs1/rs2 operand values.
- ex_fwd1, ex_fwd2  out  2  forward select (00 reg, 01 WB, 10 MEM); for debug/coverage.

Behaviour:
- Reset (async, reset=0): ex_valid, ex_reg_write, ex_is_load = 0; all registered data/control = 0. ex_op1/ex_op2 therefore read 0. No bubble pending.
- Load-use hazard (combinational): hz = ex_valid & ex_is_load & ex_rd!=0 & id_valid & (id_rs1==ex_rd | id_rs2==ex_rd). A source that the instruction does not use still compares; the conservative stall is accepted.
- id_stall = (hz | mem_stall) & ~flush.
- Register update priority, per rising edge:
  1. flush=1: ex_valid <= 0, ex_reg_write <= 0, ex_is_load <= 0; data fields don't-care. Flush wins over mem_stall and hz.
  2. else mem_stall=1: all ID/EX registers hold.
  3. else hz=1: insert bubble (ex_valid, ex_reg_write, ex_is_load <= 0). Decode is held by id_stall, so the same instruction re-presents next cycle. Exactly one bubble cycle per load-use.
  4. else: capture all id_* fields; ex_valid <= id_valid; ex_reg_write <= id_reg_write & id_valid.
- Forwarding (combinational from registered rs1/rs2 indices stored in the stage):
  - MEM source selected if mem_reg_write & mem_rd!=0 & mem_rd==ex_rs; else WB source if wb_reg_write & wb_rd!=0 & wb_rd==ex_rs; else registered rd1/rd2.
  - MEM has priority over WB when both match.
  - Index 0 never forwards; operand stays 0.
- No forwarding from WB into the captured id_rd1/id_rd2. The register file writes on the falling edge, so same-cycle decode reads already see WB data.
- Latency: one cycle ID→EX; forwarding adds zero cycles.
- Reset asserted mid-stall clears the pending bubble/hold immediately. After release, the first capture is a fresh id_* sample.

Decomposition:
- Shared package core_pkg: XLEN, CTRL_W, the ctrl bundle struct (alu_op, op1_sel, op2_sel, mem_op, br_type), and FWD_REG/FWD_WB/FWD_MEM encodings.
- One sub-module: fwd_mux (pure combinational select for one operand), instantiated twice.

Test Plan:
- Reset held, then released with id_valid=1, id_rd1=0x11, id_rd2=0x22 → after one clk ex_valid=1, ex_op1=0x11, ex_op2=0x22, ex_fwd=00.
- Load-use: EX holds lw x5 (ex_is_load=1, ex_rd=5); ID presents add x6,x5,x1 → id_stall=1 for exactly one cycle, next cycle ex_valid=0, following cycle add captured with ex_valid=1.
- Double match: mem_rd=3 with mem_result=0xAAAA, wb_rd=3 with wb_result=0xBBBB, ex rs1=3 → ex_op1=0xAAAA, ex_fwd1=10. Remove the MEM match → ex_op1=0xBBBB, ex_fwd1=01.
- x0 guard: mem_rd=0, mem_reg_write=1, mem_result=0xFFFF_FFFF, ex rs1=0 → ex_op1=0, ex_fwd1=00.
- flush and mem_stall and hz asserted together → id_stall=0, next cycle ex_valid=0, ex_reg_write=0.
- mem_stall held 3 cycles with changing id_* → ex_pc/ex_imm/ex_ctrl unchanged throughout; id_stall=1 each cycle; capture occurs on the first edge after mem_stall drops.

Source files
------------

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared widths, decoded-control bundle and forward-select encodings
package core_pkg;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 16;

  // Packed decoded-control bundle carried from decode into execute
  typedef struct packed {
    logic [3:0] alu_op;
    logic [1:0] op1_sel;
    logic [1:0] op2_sel;
    logic [3:0] mem_op;
    logic [3:0] br_type;
  } ctrl_t;

  // Operand source select reported by the forwarding muxes
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // A write to x0 is architecturally dropped, so it can never be a forward source
  function automatic logic fwd_hit(input logic we, input logic [4:0] dst, input logic [4:0] src);
    return we && (dst != 5'd0) && (dst == src);
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// rtl/fwd_mux.sv - combinational operand select for one ALU source
module fwd_mux
  import core_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic [4:0]   rs,
  input  logic [W-1:0] reg_data,
  input  logic [4:0]   mem_rd,
  input  logic         mem_reg_write,
  input  logic [W-1:0] mem_result,
  input  logic [4:0]   wb_rd,
  input  logic         wb_reg_write,
  input  logic [W-1:0] wb_result,
  output logic [W-1:0] op,
  output logic [1:0]   sel
);

  // Youngest producer wins: EX/MEM before MEM/WB before the register-file value
  always_comb begin
    op  = reg_data;
    sel = FWD_REG;
    if (fwd_hit(mem_reg_write, mem_rd, rs)) begin
      op  = mem_result;
      sel = FWD_MEM;
    end else if (fwd_hit(wb_reg_write, wb_rd, rs)) begin
      op  = wb_result;
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubble, flush, hold and forwarding
module id_ex_stage
  import core_pkg::*;
#(
  parameter int XW = XLEN,
  parameter int CW = CTRL_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [XW-1:0] id_pc,
  input  logic [4:0]    id_rs1,
  input  logic [4:0]    id_rs2,
  input  logic [4:0]    id_rd,
  input  logic [XW-1:0] id_rd1,
  input  logic [XW-1:0] id_rd2,
  input  logic [XW-1:0] id_imm,
  input  logic [CW-1:0] id_ctrl,
  input  logic          id_reg_write,
  input  logic          id_is_load,
  input  logic          flush,
  input  logic          mem_stall,
  input  logic [4:0]    mem_rd,
  input  logic          mem_reg_write,
  input  logic [XW-1:0] mem_result,
  input  logic [4:0]    wb_rd,
  input  logic          wb_reg_write,
  input  logic [XW-1:0] wb_result,
  output logic          id_stall,
  output logic          ex_valid,
  output logic [XW-1:0] ex_pc,
  output logic [XW-1:0] ex_imm,
  output logic [CW-1:0] ex_ctrl,
  output logic [4:0]    ex_rd,
  output logic          ex_reg_write,
  output logic          ex_is_load,
  output logic [XW-1:0] ex_op1,
  output logic [XW-1:0] ex_op2,
  output logic [1:0]    ex_fwd1,
  output logic [1:0]    ex_fwd2
);

  logic          valid_q, valid_d;
  logic          reg_write_q, reg_write_d;
  logic          is_load_q, is_load_d;
  logic [XW-1:0] pc_q, pc_d;
  logic [XW-1:0] imm_q, imm_d;
  logic [CW-1:0] ctrl_q, ctrl_d;
  logic [4:0]    rd_q, rd_d;
  logic [4:0]    rs1_q, rs1_d;
  logic [4:0]    rs2_q, rs2_d;
  logic [XW-1:0] rd1_q, rd1_d;
  logic [XW-1:0] rd2_q, rd2_d;
  logic          hz;

  // Load in EX feeding either source of the decode instruction; unused sources still compare
  always_comb begin
    hz = valid_q && is_load_q && (rd_q != 5'd0) && id_valid &&
         ((id_rs1 == rd_q) || (id_rs2 == rd_q));
    id_stall = (hz || mem_stall) && !flush;
  end

  // Next state: flush kills, else memory back-pressure holds, else load-use bubbles, else capture
  always_comb begin
    valid_d     = valid_q;
    reg_write_d = reg_write_q;
    is_load_d   = is_load_q;
    pc_d        = pc_q;
    imm_d       = imm_q;
    ctrl_d      = ctrl_q;
    rd_d        = rd_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd1_d       = rd1_q;
    rd2_d       = rd2_q;
    if (flush) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      is_load_d   = 1'b0;
    end else if (mem_stall) begin
      // hold everything
    end else if (hz) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      is_load_d   = 1'b0;
    end else begin
      valid_d     = id_valid;
      reg_write_d = id_reg_write && id_valid;
      is_load_d   = id_is_load && id_valid;
      pc_d        = id_pc;
      imm_d       = id_imm;
      ctrl_d      = id_ctrl;
      rd_d        = id_rd;
      rs1_d       = id_rs1;
      rs2_d       = id_rs2;
      rd1_d       = id_rd1;
      rd2_d       = id_rd2;
    end
  end

  // Stage registers; asynchronous clear leaves no bubble or hold pending
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      is_load_q   <= 1'b0;
      pc_q        <= '0;
      imm_q       <= '0;
      ctrl_q      <= '0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd1_q       <= '0;
      rd2_q       <= '0;
    end else begin
      valid_q     <= valid_d;
      reg_write_q <= reg_write_d;
      is_load_q   <= is_load_d;
      pc_q        <= pc_d;
      imm_q       <= imm_d;
      ctrl_q      <= ctrl_d;
      rd_q        <= rd_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd1_q       <= rd1_d;
      rd2_q       <= rd2_d;
    end
  end

  fwd_mux #(.W(XW)) u_fwd1 (
    .rs(rs1_q), .reg_data(rd1_q),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .op(ex_op1), .sel(ex_fwd1)
  );

  fwd_mux #(.W(XW)) u_fwd2 (
    .rs(rs2_q), .reg_data(rd2_q),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .op(ex_op2), .sel(ex_fwd2)
  );

  assign ex_valid     = valid_q;
  assign ex_reg_write = reg_write_q;
  assign ex_is_load   = is_load_q;
  assign ex_pc        = pc_q;
  assign ex_imm       = imm_q;
  assign ex_ctrl      = ctrl_q;
  assign ex_rd        = rd_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_pc, id_rd1, id_rd2, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [15:0] id_ctrl;
  logic        id_reg_write, id_is_load, flush, mem_stall;
  logic [4:0]  mem_rd, wb_rd;
  logic        mem_reg_write, wb_reg_write;
  logic [31:0] mem_result, wb_result;
  logic        id_stall, ex_valid, ex_reg_write, ex_is_load;
  logic [31:0] ex_pc, ex_imm, ex_op1, ex_op2;
  logic [15:0] ex_ctrl;
  logic [4:0]  ex_rd;
  logic [1:0]  ex_fwd1, ex_fwd2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_rd1(id_rd1), .id_rd2(id_rd2),
    .id_imm(id_imm), .id_ctrl(id_ctrl), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .flush(flush), .mem_stall(mem_stall),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .id_stall(id_stall), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_ctrl(ex_ctrl), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
    .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_fwd1(ex_fwd1), .ex_fwd2(ex_fwd2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic present(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [31:0] rd1, input logic [31:0] rd2,
                         input logic wr, input logic ld);
    id_valid = 1'b1; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rd1 = rd1; id_rd2 = rd2; id_reg_write = wr; id_is_load = ld;
  endtask

  initial begin
    reset = 1'b0;
    id_valid = 0; id_pc = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_rd1 = 0; id_rd2 = 0;
    id_imm = 0; id_ctrl = 0; id_reg_write = 0; id_is_load = 0; flush = 0; mem_stall = 0;
    mem_rd = 0; mem_reg_write = 0; mem_result = 0; wb_rd = 0; wb_reg_write = 0; wb_result = 0;
    repeat (2) @(negedge clk);
    check("rst_valid", ex_valid, 0);
    check("rst_op1", ex_op1, 0);
    check("rst_op2", ex_op2, 0);
    check("rst_stall", id_stall, 0);

    // first capture after reset release
    present(32'h100, 5'd1, 5'd2, 5'd7, 32'h11, 32'h22, 1'b1, 1'b0);
    id_imm = 32'h4; id_ctrl = 16'h1234;
    reset = 1'b1;
    step();
    check("cap_valid", ex_valid, 1);
    check("cap_op1", ex_op1, 32'h11);
    check("cap_op2", ex_op2, 32'h22);
    check("cap_fwd", {ex_fwd1, ex_fwd2}, 4'b0000);
    check("cap_pc", ex_pc, 32'h100);
    check("cap_ctrl", ex_ctrl, 16'h1234);
    check("cap_rd", ex_rd, 7);
    check("cap_wr", ex_reg_write, 1);

    // load-use: lw x5 then add x6,x5,x1
    present(32'h104, 5'd2, 5'd0, 5'd5, 32'h0, 32'h0, 1'b1, 1'b1);
    step();
    check("lw_is_load", ex_is_load, 1);
    present(32'h108, 5'd5, 5'd1, 5'd6, 32'h55, 32'h1, 1'b1, 1'b0);
    #1 check("lu_stall", id_stall, 1);
    step();
    check("lu_bubble_valid", ex_valid, 0);
    check("lu_bubble_wr", ex_reg_write, 0);
    check("lu_stall_gone", id_stall, 0);
    step();
    check("lu_add_valid", ex_valid, 1);
    check("lu_add_pc", ex_pc, 32'h108);
    check("lu_add_rd", ex_rd, 6);

    // forwarding priority on rs1=3
    present(32'h10c, 5'd3, 5'd4, 5'd8, 32'h33, 32'h44, 1'b1, 1'b0);
    step();
    mem_rd = 5'd3; mem_reg_write = 1; mem_result = 32'hAAAA;
    wb_rd = 5'd3; wb_reg_write = 1; wb_result = 32'hBBBB;
    #1 check("fwd_mem_op1", ex_op1, 32'hAAAA);
    check("fwd_mem_sel", ex_fwd1, 2'b10);
    check("fwd_op2_reg", ex_op2, 32'h44);
    check("fwd_op2_sel", ex_fwd2, 2'b00);
    mem_reg_write = 0;
    #1 check("fwd_wb_op1", ex_op1, 32'hBBBB);
    check("fwd_wb_sel", ex_fwd1, 2'b01);
    wb_rd = 5'd4;
    #1 check("fwd_wb_op2", ex_op2, 32'hBBBB);
    check("fwd_op1_back", ex_op1, 32'h33);
    wb_reg_write = 0;

    // x0 never forwards
    present(32'h110, 5'd0, 5'd0, 5'd9, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    mem_rd = 5'd0; mem_reg_write = 1; mem_result = 32'hFFFF_FFFF;
    #1 check("x0_op1", ex_op1, 0);
    check("x0_sel", ex_fwd1, 2'b00);
    mem_reg_write = 0;

    // flush beats mem_stall and hazard
    present(32'h114, 5'd1, 5'd2, 5'd9, 32'h0, 32'h0, 1'b1, 1'b1);
    step();
    present(32'h118, 5'd9, 5'd2, 5'd10, 32'h0, 32'h0, 1'b1, 1'b0);
    mem_stall = 1; flush = 1;
    #1 check("fl_stall", id_stall, 0);
    step();
    check("fl_valid", ex_valid, 0);
    check("fl_wr", ex_reg_write, 0);
    check("fl_ld", ex_is_load, 0);
    flush = 0; mem_stall = 0;

    // mem_stall hold for 3 cycles
    present(32'h200, 5'd1, 5'd2, 5'd11, 32'h0, 32'h0, 1'b1, 1'b0);
    id_imm = 32'h55; id_ctrl = 16'hBEEF;
    step();
    mem_stall = 1;
    for (int i = 0; i < 3; i++) begin
      id_pc = 32'h300 + 32'(4 * i); id_imm = 32'h60 + 32'(i); id_ctrl = 16'h0100 + 16'(i);
      #1 check("hold_stall", id_stall, 1);
      step();
      check("hold_pc", ex_pc, 32'h200);
      check("hold_imm", ex_imm, 32'h55);
      check("hold_ctrl", ex_ctrl, 16'hBEEF);
    end
    mem_stall = 0; id_pc = 32'h400; id_imm = 32'h77; id_ctrl = 16'h4242;
    step();
    check("rel_pc", ex_pc, 32'h400);
    check("rel_imm", ex_imm, 32'h77);
    check("rel_ctrl", ex_ctrl, 16'h4242);

    // reset mid-hazard clears immediately
    present(32'h500, 5'd1, 5'd2, 5'd12, 32'h0, 32'h0, 1'b1, 1'b1);
    step();
    present(32'h504, 5'd12, 5'd0, 5'd13, 32'h99, 32'h0, 1'b1, 1'b0);
    #1 check("mr_stall_pre", id_stall, 1);
    reset = 1'b0;
    #1 check("mr_valid", ex_valid, 0);
    check("mr_stall", id_stall, 0);
    @(negedge clk);
    reset = 1'b1;
    step();
    check("mr_fresh_pc", ex_pc, 32'h504);
    check("mr_fresh_op1", ex_op1, 32'h99);
    check("mr_fresh_valid", ex_valid, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
